pc_sequencer: RTL and testbench

//  Fetch-side controller for the program counter register. Owns the run/halt

---
 rtl/pc_seq_pkg.sv | 23 ++
 rtl/pc_ras.sv | 71 +++++++
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared constants and enums for the program-counter sequencer.
// Build option PC_RAS_EN (see pc_sequencer) enables the return-address stack.
package pc_seq_pkg;
  localparam int PC_W      = 16;
  localparam int OFF_W     = 8;
  localparam int RAS_DEPTH = 4;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_seq_state_t;

  typedef enum logic [2:0] {
    SRC_ZERO   = 3'd0,
    SRC_HOLD   = 3'd1,
    SRC_RET    = 3'd2,
    SRC_TARGET = 3'd3,
    SRC_BRANCH = 3'd4,
    SRC_SEQ    = 3'd5
  } pc_src_t;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// and a pop when empty leaves the stack unchanged; both set the sticky error.
module pc_ras #(
  parameter int PC_W  = pc_seq_pkg::PC_W,
  parameter int DEPTH = pc_seq_pkg::RAS_DEPTH
) (
  input  logic            CLK,
  input  logic            reset_ctrl,
  input  logic            push_in,
  input  logic            pop_in,
  input  logic [PC_W-1:0] push_data_in,
  output logic [PC_W-1:0] pop_data_out,
  output logic            empty_out,
  output logic            full_out,
  output logic            err_out
);
  import pc_seq_pkg::*;

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST     = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PC_W-1:0]  mem_q [DEPTH];
  logic [PC_W-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_idx, wr_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // wr_q is the next free slot; the top of stack sits just below it
  assign rd_idx       = (wr_q == '0) ? LAST : wr_q - PTR_W'(1);
  assign wr_inc       = (wr_q == LAST) ? '0 : wr_q + PTR_W'(1);
  assign empty_out    = (cnt_q == '0);
  assign full_out     = (cnt_q == FULL_CNT);
  assign pop_data_out = mem_q[rd_idx];
  assign err_out      = err_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (pop_in) begin
      if (empty_out) begin
        err_d = 1'b1;
      end else begin
        wr_d  = rd_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end else if (push_in) begin
      mem_d[wr_q] = push_data_in;
      wr_d        = wr_inc;
      if (full_out) err_d = 1'b1;
      else          cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge reset_ctrl) begin
    if (!reset_ctrl) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC controller: run/halt FSM, combinational next-PC select, RUN cycle counter.
// Define PC_RAS_EN to add call/return through the pc_ras stack.
//
//  state  | meaning
//  IDLE   | PC register held in reset, pcnext 0, waiting for start_in
//  RUN    | fetching; pcnext chosen from hold/ret/call/jump/branch/sequential
//  HALTED | halt decoded; PC frozen, done_out high, start_in resumes
module pc_sequencer #(
  parameter int PC_W      = pc_seq_pkg::PC_W,
  parameter int OFF_W     = pc_seq_pkg::OFF_W,
  parameter int RAS_DEPTH = pc_seq_pkg::RAS_DEPTH
) (
  input  logic             CLK,
  input  logic             reset_ctrl,
  input  logic             start_in,
  input  logic             halt_in,
  input  logic             stall_in,
  input  logic             branch_ctrl,
  input  logic             branch_taken_in,
  input  logic [OFF_W-1:0] branch_off_in,
  input  logic             jump_ctrl,
  input  logic             call_ctrl,
  input  logic             ret_ctrl,
  input  logic [PC_W-1:0]  jump_target_in,
  input  logic [PC_W-1:0]  pc_in,
  output logic [PC_W-1:0]  pcnext_out,
  output logic             pc_reset_out,
  output logic             done_out,
  output logic [15:0]      cycle_count_out,
  output logic             ras_err_out
);
  import pc_seq_pkg::*;

  pc_seq_state_t   state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  pc_src_t         src;
  logic [PC_W-1:0] pc_plus1, pc_branch;

  assign pc_plus1  = pc_in + PC_W'(1);
  assign pc_branch = pc_in + {{(PC_W-OFF_W){branch_off_in[OFF_W-1]}}, branch_off_in} + PC_W'(1);
  assign cycle_count_out = cnt_q;

`ifdef PC_RAS_EN
  logic            push, pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            unused_ras_full;

  pc_ras #(.PC_W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .CLK          (CLK),
    .reset_ctrl   (reset_ctrl),
    .push_in      (push),
    .pop_in       (pop),
    .push_data_in (pc_plus1),
    .pop_data_out (ras_top),
    .empty_out    (ras_empty),
    .full_out     (unused_ras_full),
    .err_out      (ras_err_out)
  );
`else
  localparam int unused_ras_depth = RAS_DEPTH;
  logic unused_ret;
  assign unused_ret  = ret_ctrl;
  assign ras_err_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    src          = SRC_SEQ;
    pc_reset_out = 1'b0;
    done_out     = 1'b0;
`ifdef PC_RAS_EN
    push = 1'b0;
    pop  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        src          = SRC_ZERO;
        pc_reset_out = 1'b1;
        if (start_in) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        // stall outranks halt: a stalled halt stays in RUN with the PC held
        if (halt_in || stall_in) begin
          src = SRC_HOLD;
          if (!stall_in) state_d = HALTED;
        end
`ifdef PC_RAS_EN
        else if (ret_ctrl) begin
          src = SRC_RET;
          pop = 1'b1;
        end else if (call_ctrl) begin
          src  = SRC_TARGET;
          push = 1'b1;
        end
`else
        else if (call_ctrl) src = SRC_TARGET;
`endif
        else if (jump_ctrl) src = SRC_TARGET;
        else if (branch_ctrl && branch_taken_in) src = SRC_BRANCH;
        else src = SRC_SEQ;
      end
      HALTED: begin
        src      = SRC_HOLD;
        done_out = 1'b1;
        if (start_in) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        src          = SRC_ZERO;
        pc_reset_out = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  always_comb begin
    pcnext_out = pc_plus1;
    case (src)
      SRC_ZERO:   pcnext_out = '0;
      SRC_HOLD:   pcnext_out = pc_in;
`ifdef PC_RAS_EN
      SRC_RET:    pcnext_out = ras_empty ? pc_plus1 : ras_top;
`else
      SRC_RET:    pcnext_out = pc_plus1;
`endif
      SRC_TARGET: pcnext_out = jump_target_in;
      SRC_BRANCH: pcnext_out = pc_branch;
      default:    pcnext_out = pc_plus1;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_ctrl) begin
    if (!reset_ctrl) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: behavioural model (mode number, counter, queue stack)
// compared every negedge, plus literal directed checks and a random phase.
module tb_pc_sequencer;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        reset_ctrl = 1'b0;
  logic        start_in = 1'b0, halt_in = 1'b0, stall_in = 1'b0;
  logic        branch_ctrl = 1'b0, branch_taken_in = 1'b0;
  logic [7:0]  branch_off_in = '0;
  logic        jump_ctrl = 1'b0, call_ctrl = 1'b0, ret_ctrl = 1'b0;
  logic [15:0] jump_target_in = '0;
  logic [15:0] pc_in;
  logic [15:0] pcnext_out;
  logic        pc_reset_out, done_out, ras_err_out;
  logic [15:0] cycle_count_out;

  logic [15:0] pc_drv = '0;
  logic [15:0] pc_reg = '0;
  logic        loop_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  // model: 0 = idle, 1 = running, 2 = halted
  int          m_st = 0;
  logic [15:0] m_cnt = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_ras[$];

  always #5 CLK = ~CLK;

  assign pc_in = loop_mode ? pc_reg : pc_drv;
  always @(posedge CLK) pc_reg <= pc_reset_out ? 16'h0000 : pcnext_out;

  pc_sequencer dut (
    .CLK             (CLK),
    .reset_ctrl      (reset_ctrl),
    .start_in        (start_in),
    .halt_in         (halt_in),
    .stall_in        (stall_in),
    .branch_ctrl     (branch_ctrl),
    .branch_taken_in (branch_taken_in),
    .branch_off_in   (branch_off_in),
    .jump_ctrl       (jump_ctrl),
    .call_ctrl       (call_ctrl),
    .ret_ctrl        (ret_ctrl),
    .jump_target_in  (jump_target_in),
    .pc_in           (pc_in),
    .pcnext_out      (pcnext_out),
    .pc_reset_out    (pc_reset_out),
    .done_out        (done_out),
    .cycle_count_out (cycle_count_out),
    .ras_err_out     (ras_err_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_pcnext();
    int sum;
    if (!reset_ctrl || m_st == 0) return 16'h0000;
    if (m_st == 2 || halt_in || stall_in) return pc_in;
`ifdef PC_RAS_EN
    if (ret_ctrl) return (m_ras.size() == 0) ? pc_in + 16'd1 : m_ras[$];
`endif
    if (call_ctrl || jump_ctrl) return jump_target_in;
    if (branch_ctrl && branch_taken_in) begin
      sum = int'(pc_in) + int'($signed(branch_off_in)) + 1;
      return 16'(sum & 32'h0000FFFF);
    end
    return 16'(int'(pc_in) + 1);
  endfunction

  task automatic model_loop();
    forever begin
      @(posedge CLK or negedge reset_ctrl);
      if (!reset_ctrl) begin
        m_st  = 0;
        m_cnt = '0;
        m_err = 1'b0;
        m_ras.delete();
      end else if (m_st == 1) begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (!stall_in) begin
          if (halt_in) m_st = 2;
`ifdef PC_RAS_EN
          else if (ret_ctrl) begin
            if (m_ras.size() == 0) m_err = 1'b1;
            else void'(m_ras.pop_back());
          end else if (call_ctrl) begin
            m_ras.push_back(pc_in + 16'd1);
            if (m_ras.size() > DEPTH) begin
              void'(m_ras.pop_front());
              m_err = 1'b1;
            end
          end
`endif
        end
      end else if (start_in) begin
        m_st  = 1;
        m_cnt = '0;
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge CLK);
      chk("pcnext",   {16'h0, pcnext_out},      {16'h0, exp_pcnext()});
      chk("pc_reset", {31'h0, pc_reset_out},    {31'h0, (!reset_ctrl || m_st == 0)});
      chk("done",     {31'h0, done_out},        {31'h0, (reset_ctrl && m_st == 2)});
      chk("count",    {16'h0, cycle_count_out}, {16'h0, m_cnt});
      chk("ras_err",  {31'h0, ras_err_out},     {31'h0, m_err});
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    fork
      model_loop();
      compare_loop();
    join_none

    repeat (2) cyc();
    chk("rst_pc_reset", {31'h0, pc_reset_out},    32'h1);
    chk("rst_pcnext",   {16'h0, pcnext_out},      32'h0);
    chk("rst_done",     {31'h0, done_out},        32'h0);
    chk("rst_count",    {16'h0, cycle_count_out}, 32'h0);
    chk("rst_ras_err",  {31'h0, ras_err_out},     32'h0);
    reset_ctrl = 1'b1;
    cyc();

    // start with the PC register closed around the DUT
    loop_mode = 1'b1;
    start_in  = 1'b1;
    cyc();
    start_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("pc_seq", {16'h0, pc_in}, i);
      cyc();
    end
    chk("count5", {16'h0, cycle_count_out}, 32'd5);

    // reset mid-run
    loop_mode = 1'b0;
    pc_drv    = 16'h0042;
    #1 chk("run_0042", {16'h0, pcnext_out}, 32'h0043);
    reset_ctrl = 1'b0;
    #1;
    chk("mid_rst_pc_reset", {31'h0, pc_reset_out},    32'h1);
    chk("mid_rst_count",    {16'h0, cycle_count_out}, 32'h0);
    chk("mid_rst_pcnext",   {16'h0, pcnext_out},      32'h0);
    cyc();
    reset_ctrl = 1'b1;
    cyc();
    start_in = 1'b1;
    cyc();
    start_in = 1'b0;

    pc_drv = 16'h0010; branch_ctrl = 1'b1; branch_taken_in = 1'b1; branch_off_in = 8'hFC;
    #1 chk("br_taken", {16'h0, pcnext_out}, 32'h000D);
    branch_taken_in = 1'b0;
    #1 chk("br_not_taken", {16'h0, pcnext_out}, 32'h0011);
    cyc();
    branch_ctrl = 1'b0; pc_drv = 16'hFFFF;
    #1 chk("seq_wrap", {16'h0, pcnext_out}, 32'h0000);
    pc_drv = 16'h0000; branch_ctrl = 1'b1; branch_taken_in = 1'b1; branch_off_in = 8'h80;
    #1 chk("br_neg_wrap", {16'h0, pcnext_out}, 32'hFF81);
    cyc();
    branch_ctrl = 1'b0; branch_taken_in = 1'b0;
    pc_drv = 16'h1234; jump_ctrl = 1'b1; jump_target_in = 16'hBEEF; stall_in = 1'b1;
    #1 chk("jump_stall", {16'h0, pcnext_out}, 32'h1234);
    stall_in = 1'b0;
    #1 chk("jump", {16'h0, pcnext_out}, 32'hBEEF);
    cyc();
    jump_ctrl = 1'b0;

    pc_drv = 16'h0300; halt_in = 1'b1; stall_in = 1'b1;
    cyc();
    chk("halt_stall_done", {31'h0, done_out}, 32'h0);
    stall_in = 1'b0;
    #1 chk("halt_hold", {16'h0, pcnext_out}, 32'h0300);
    cyc();
    halt_in = 1'b0;
    chk("halted_done", {31'h0, done_out}, 32'h1);
    jump_ctrl = 1'b1; jump_target_in = 16'h5555;
    #1 chk("halted_frozen", {16'h0, pcnext_out}, 32'h0300);
    cyc();
    jump_ctrl = 1'b0;
    chk("halted_done2", {31'h0, done_out}, 32'h1);
    start_in = 1'b1;
    cyc();
    start_in = 1'b0;
    chk("restart_count", {16'h0, cycle_count_out}, 32'h0);

`ifdef PC_RAS_EN
    pc_drv = 16'h0020; call_ctrl = 1'b1; jump_target_in = 16'h0100;
    #1 chk("call", {16'h0, pcnext_out}, 32'h0100);
    cyc();
    call_ctrl = 1'b0; pc_drv = 16'h0100; ret_ctrl = 1'b1;
    #1 chk("ret", {16'h0, pcnext_out}, 32'h0021);
    cyc();
    ret_ctrl = 1'b0;
    chk("ras_ok", {31'h0, ras_err_out}, 32'h0);
    call_ctrl = 1'b1; pc_drv = 16'h0040;
    repeat (4) cyc();
    chk("ras_full_ok", {31'h0, ras_err_out}, 32'h0);
    cyc();
    chk("ras_overflow", {31'h0, ras_err_out}, 32'h1);
    call_ctrl = 1'b0;
`else
    pc_drv = 16'h0020; call_ctrl = 1'b1; jump_target_in = 16'h0100;
    #1 chk("call_as_jump", {16'h0, pcnext_out}, 32'h0100);
    call_ctrl = 1'b0; ret_ctrl = 1'b1;
    #1 chk("ret_ignored", {16'h0, pcnext_out}, 32'h0021);
    ret_ctrl = 1'b0;
    cyc();
    chk("ras_err_tied", {31'h0, ras_err_out}, 32'h0);
`endif

    for (int n = 0; n < 3000; n++) begin
      reset_ctrl      = ($urandom_range(0, 99) != 0);
      start_in        = ($urandom_range(0, 7) == 0);
      halt_in         = ($urandom_range(0, 9) == 0);
      stall_in        = ($urandom_range(0, 4) == 0);
      ret_ctrl        = ($urandom_range(0, 5) == 0);
      call_ctrl       = ($urandom_range(0, 5) == 0);
      jump_ctrl       = ($urandom_range(0, 7) == 0);
      branch_ctrl     = ($urandom_range(0, 2) == 0);
      branch_taken_in = $urandom_range(0, 1) == 1;
      branch_off_in   = 8'($urandom);
      jump_target_in  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       pc_drv = 16'hFFFF;
        1:       pc_drv = 16'h0000;
        default: pc_drv = 16'($urandom);
      endcase
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
